// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the true-dual-port RAM front-end controller.
//   ctrl_state_e : controller state (array clear, normal service)
//   port_e       : requester identity, also the round-robin pointer encoding
//   addr_w()     : address width for a given word depth
package tdp_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tdp_ram_port_ctrl_if.sv
// Request/response channel between one requester and the RAM controller.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_we              : 1 = write, 0 = read
//   req_addr/req_wdata  : request address and write data
//   rsp_valid           : one-cycle response pulse, one cycle after acceptance
//   rsp_rdata           : read data, or the write data echoed back on a write
// master = requester side, slave = controller side.
interface tdp_ram_port_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/tdp_rr_arb2.sv
// Two-requester round-robin arbiter for same-address write/write collisions.
//   req[1:0] : request valid per port (bit 0 = A, bit 1 = B)
//   collide  : the two requests conflict this cycle
//   grant    : requests allowed through; on a collision only the pointer's port
//   ptr      : priority pointer, flips after every collision so the loser wins next
module tdp_rr_arb2
    import tdp_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       collide,
    output logic [1:0] grant,
    output port_e      ptr
);
    always_comb begin
        grant = req;
        if (collide) grant = req & ((ptr == PORT_A) ? 2'b01 : 2'b10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PORT_A;
        end else if (collide) begin
            ptr <= (ptr == PORT_A) ? PORT_B : PORT_A;
        end
    end
endmodule

// File: rtl/true_dual_port_ram.sv
// Plain true dual-port RAM, one clock, registered read on each port.
//   we_x/addr_x/data_x : port x write enable, address, write data
//   q_x                : port x read data, valid the cycle after the address
// A read of a word written by the other port in the same cycle returns the
// old contents; the controller in front of this RAM forwards that case.
module true_dual_port_ram
    import tdp_ram_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] q_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] q_b
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end
endmodule

// File: rtl/tdp_ram_port_ctrl.sv
// Front-end controller owning both ports of true_dual_port_ram.
//   clk, rst_n         : clock, asynchronous active-low reset
//   a_if, b_if         : requester channels (slave side)
//   ram_we/addr/data_x : RAM port x drive, combinational from the accepted request
//   ram_q_x            : RAM port x registered read data
//   init_done          : array clear finished; requests accepted only when high
//   coll_cnt           : saturating count of write/write collisions
// After reset the array is swept to zero, A covering the lower half and B the
// upper half. Same-address write/write is arbitrated round-robin; a same-address
// write/read pair is served from a registered bypass instead of the RAM.
module tdp_ram_port_ctrl
    import tdp_ram_pkg::*;
#(
    parameter  int WIDTH          = 8,
    parameter  int DEPTH          = 64,
    parameter  int CLEAR_ON_RESET = 1,
    parameter  int CNT_W          = 16,
    localparam int AW             = addr_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    tdp_ram_port_ctrl_if.slave a_if,
    tdp_ram_port_ctrl_if.slave b_if,
    output logic               ram_we_a,
    output logic [AW-1:0]      ram_addr_a,
    output logic [WIDTH-1:0]   ram_data_a,
    input  logic [WIDTH-1:0]   ram_q_a,
    output logic               ram_we_b,
    output logic [AW-1:0]      ram_addr_b,
    output logic [WIDTH-1:0]   ram_data_b,
    input  logic [WIDTH-1:0]   ram_q_b,
    output logic               init_done,
    output logic [CNT_W-1:0]   coll_cnt
);
    localparam logic [AW-1:0] HALF   = AW'(DEPTH / 2);
    localparam logic [AW-1:0] LAST_K = AW'(DEPTH / 2 - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ctrl_state_e      state;
    logic [AW-1:0]    clr_k;
    logic             clearing;
    logic             collide;
    logic [1:0]       grant;
    port_e            ptr;
    logic             acc_a, acc_b;
    logic             fwd_a, fwd_b;
    logic             same_addr;

    logic             rsp_vld_a_p1, rsp_vld_b_p1;
    logic             ram_sel_a_p1, ram_sel_b_p1;
    logic [WIDTH-1:0] hold_a_p1, hold_b_p1;

    assign same_addr = (a_if.req_addr == b_if.req_addr);
    assign collide   = init_done & a_if.req_valid & b_if.req_valid
                     & a_if.req_we & b_if.req_we & same_addr;

    tdp_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({b_if.req_valid, a_if.req_valid}),
        .collide (collide),
        .grant   (grant),
        .ptr     (ptr)
    );

    assign a_if.req_ready = init_done & ~(collide & (ptr == PORT_B));
    assign b_if.req_ready = init_done & ~(collide & (ptr == PORT_A));
    assign acc_a = init_done & grant[0];
    assign acc_b = init_done & grant[1];

    // A reader paired with a same-address writer on the other port takes the
    // written data; the RAM would return the old word.
    assign fwd_a = acc_a & ~a_if.req_we & acc_b & b_if.req_we & same_addr;
    assign fwd_b = acc_b & ~b_if.req_we & acc_a & a_if.req_we & same_addr;

    // Gated by rst_n so the clear writes stop the instant reset asserts.
    assign clearing = rst_n & (state == INIT);

    always_comb begin
        ram_we_a   = acc_a & a_if.req_we;
        ram_addr_a = a_if.req_addr;
        ram_data_a = a_if.req_wdata;
        ram_we_b   = acc_b & b_if.req_we;
        ram_addr_b = b_if.req_addr;
        ram_data_b = b_if.req_wdata;
        if (clearing) begin
            ram_we_a   = 1'b1;
            ram_addr_a = clr_k;
            ram_data_a = '0;
            ram_we_b   = 1'b1;
            ram_addr_b = clr_k + HALF;
            ram_data_b = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clr_k     <= '0;
            init_done <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_k <= clr_k + AW'(1);
                    if (clr_k == LAST_K) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    if (collide) coll_cnt <= sat_inc(coll_cnt);
                end
            endcase
        end
    end

    // ---- stage p1: response one cycle after acceptance ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_a_p1 <= 1'b0;
            ram_sel_a_p1 <= 1'b0;
            hold_a_p1    <= '0;
            rsp_vld_b_p1 <= 1'b0;
            ram_sel_b_p1 <= 1'b0;
            hold_b_p1    <= '0;
        end else begin
            rsp_vld_a_p1 <= acc_a;
            rsp_vld_b_p1 <= acc_b;
            if (acc_a) begin
                ram_sel_a_p1 <= ~a_if.req_we & ~fwd_a;
                hold_a_p1    <= fwd_a ? b_if.req_wdata : a_if.req_wdata;
            end
            if (acc_b) begin
                ram_sel_b_p1 <= ~b_if.req_we & ~fwd_b;
                hold_b_p1    <= fwd_b ? a_if.req_wdata : b_if.req_wdata;
            end
        end
    end

    assign a_if.rsp_valid = rsp_vld_a_p1;
    assign a_if.rsp_rdata = ram_sel_a_p1 ? ram_q_a : hold_a_p1;
    assign b_if.rsp_valid = rsp_vld_b_p1;
    assign b_if.rsp_rdata = ram_sel_b_p1 ? ram_q_b : hold_b_p1;
endmodule

// File: tb/tb_tdp_ram_port_ctrl.sv
// Directed plus randomized bench for tdp_ram_port_ctrl driving true_dual_port_ram.
// The reference model is a plain word array, a one-bit priority token and an
// integer collision count, updated from the request/accept rules.
module tb_tdp_ram_port_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdp_ram_port_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) a_if ();
    tdp_ram_port_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) b_if ();

    logic             ram_we_a, ram_we_b;
    logic [AW-1:0]    ram_addr_a, ram_addr_b;
    logic [WIDTH-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic             init_done;
    logic [CNT_W-1:0] coll_cnt;

    tdp_ram_port_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_ON_RESET(1), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_if       (a_if),
        .b_if       (b_if),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_q_a    (ram_q_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_q_b    (ram_q_b),
        .init_done  (init_done),
        .coll_cnt   (coll_cnt)
    );

    true_dual_port_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we_a   (ram_we_a),
        .addr_a (ram_addr_a),
        .data_a (ram_data_a),
        .q_a    (ram_q_a),
        .we_b   (ram_we_b),
        .addr_b (ram_addr_b),
        .data_b (ram_data_b),
        .q_b    (ram_q_b)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_m [DEPTH];
    bit         ptr_b_m;   // 0: A has priority, 1: B has priority
    int         cnt_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        ptr_b_m = 1'b0;
        cnt_m   = 0;
    endtask

    // One clock of traffic, starting just after a rising edge.
    task automatic step(input bit av, input bit aw, input logic [AW-1:0] aa, input logic [7:0] ad,
                        input bit bv, input bit bw, input logic [AW-1:0] ba, input logic [7:0] bd,
                        output bit acc_a, output bit acc_b);
        bit         coll, ra, rb;
        logic [7:0] ea, eb;
        a_if.req_valid = av; a_if.req_we = aw; a_if.req_addr = aa; a_if.req_wdata = ad;
        b_if.req_valid = bv; b_if.req_we = bw; b_if.req_addr = ba; b_if.req_wdata = bd;
        coll = av && bv && aw && bw && (aa == ba);
        ra = !(coll && ptr_b_m);
        rb = !(coll && !ptr_b_m);
        @(negedge clk);
        chk("a_ready", 32'(a_if.req_ready), 32'(ra));
        chk("b_ready", 32'(b_if.req_ready), 32'(rb));
        acc_a = av && ra;
        acc_b = bv && rb;
        ea = aw ? ad : ((acc_b && bw && ba == aa) ? bd : mem_m[aa]);
        eb = bw ? bd : ((acc_a && aw && aa == ba) ? ad : mem_m[ba]);
        if (acc_a && aw) mem_m[aa] = ad;
        if (acc_b && bw) mem_m[ba] = bd;
        if (coll) begin
            ptr_b_m = !ptr_b_m;
            if (cnt_m < CMAX) cnt_m++;
        end
        @(posedge clk);
        #1;
        chk("a_rsp_valid", 32'(a_if.rsp_valid), 32'(acc_a));
        chk("b_rsp_valid", 32'(b_if.rsp_valid), 32'(acc_b));
        if (acc_a) chk("a_rsp_rdata", 32'(a_if.rsp_rdata), 32'(ea));
        if (acc_b) chk("b_rsp_rdata", 32'(b_if.rsp_rdata), 32'(eb));
        chk("coll_cnt", 32'(coll_cnt), cnt_m);
        a_if.req_valid = 1'b0;
        b_if.req_valid = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit xa, xb;
        bit av, aw, bv, bw;
        logic [AW-1:0] aa, ba;
        logic [7:0] ad, bd;

        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0;
        model_reset();

        // T1: reset values, clear sweep, reads of cleared words
        #2;
        chk("rst_a_ready", 32'(a_if.req_ready), 0);
        chk("rst_b_ready", 32'(b_if.req_ready), 0);
        chk("rst_a_rsp_valid", 32'(a_if.rsp_valid), 0);
        chk("rst_a_rsp_rdata", 32'(a_if.rsp_rdata), 0);
        chk("rst_b_rsp_rdata", 32'(b_if.rsp_rdata), 0);
        chk("rst_ram_we_a", 32'(ram_we_a), 0);
        chk("rst_ram_we_b", 32'(ram_we_b), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_coll_cnt", 32'(coll_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_clr_we_a", 32'(ram_we_a), 1);
        chk("t1_clr_addr_a", 32'(ram_addr_a), 0);
        chk("t1_clr_addr_b", 32'(ram_addr_b), 32);
        wait_init("t1_init_cycles");
        step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0, 6'd40, 8'h00, xa, xb);
        chk("t1_read5", 32'(a_if.rsp_rdata), 32'h00);
        chk("t1_read40", 32'(b_if.rsp_rdata), 32'h00);

        // T2: write/write collisions, round-robin, final contents
        step(1'b1, 1'b1, 6'd3, 8'h11, 1'b1, 1'b1, 6'd3, 8'h22, xa, xb);
        step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 6'd3, 8'h22, xa, xb);
        step(1'b1, 1'b0, 6'd3, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, xa, xb);
        chk("t2_read3_first", 32'(a_if.rsp_rdata), 32'h22);
        chk("t2_cnt_first", 32'(coll_cnt), 1);
        step(1'b1, 1'b1, 6'd3, 8'h33, 1'b1, 1'b1, 6'd3, 8'h44, xa, xb);
        step(1'b1, 1'b1, 6'd3, 8'h33, 1'b0, 1'b0, 6'd0, 8'h00, xa, xb);
        step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd3, 8'h00, xa, xb);
        chk("t2_read3_second", 32'(b_if.rsp_rdata), 32'h33);
        chk("t2_cnt_second", 32'(coll_cnt), 2);

        // T3: write/read hazard forwarding
        step(1'b1, 1'b1, 6'd7, 8'h5A, 1'b1, 1'b0, 6'd7, 8'h00, xa, xb);
        chk("t3_b_fwd", 32'(b_if.rsp_rdata), 32'h5A);
        chk("t3_a_echo", 32'(a_if.rsp_rdata), 32'h5A);

        // T4: read/read same address, back-to-back
        step(1'b1, 1'b1, 6'd9, 8'hC3, 1'b0, 1'b0, 6'd0, 8'h00, xa, xb);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 6'd9, 8'h00, 1'b1, 1'b0, 6'd9, 8'h00, xa, xb);
            chk("t4_a_rd", 32'(a_if.rsp_rdata), 32'hC3);
            chk("t4_b_rd", 32'(b_if.rsp_rdata), 32'hC3);
            chk("t4_cnt", 32'(coll_cnt), 2);
        end

        // Randomized traffic on a narrow address window; stalled requests are held.
        xa = 1'b1; xb = 1'b1;
        av = 1'b0; aw = 1'b0; aa = '0; ad = '0;
        bv = 1'b0; bw = 1'b0; ba = '0; bd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!av || xa) begin
                av = ($urandom_range(0, 3) != 0);
                aw = 1'($urandom_range(0, 1));
                aa = AW'($urandom_range(0, 7));
                ad = 8'($urandom);
            end
            if (!bv || xb) begin
                bv = ($urandom_range(0, 3) != 0);
                bw = 1'($urandom_range(0, 1));
                ba = AW'($urandom_range(0, 7));
                bd = 8'($urandom);
            end
            step(av, aw, aa, ad, bv, bw, ba, bd, xa, xb);
        end

        // T5: reset in the middle of the clear sweep
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_mid_addr_a", 32'(ram_addr_a), 10);
        chk("t5_mid_we_b", 32'(ram_we_b), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_we_a", 32'(ram_we_a), 0);
        chk("t5_rst_we_b", 32'(ram_we_b), 0);
        chk("t5_rst_init_done", 32'(init_done), 0);
        chk("t5_rst_a_ready", 32'(a_if.req_ready), 0);
        chk("t5_rst_b_rsp_valid", 32'(b_if.rsp_valid), 0);
        chk("t5_rst_coll_cnt", 32'(coll_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_restart_addr_a", 32'(ram_addr_a), 0);
        chk("t5_restart_addr_b", 32'(ram_addr_b), 32);
        wait_init("t5_init_cycles");
        step(1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 1'b0, 6'd9, 8'h00, xa, xb);

        // T6: five collisions with a 2-bit counter; losers retry alone
        for (int i = 0; i < 5; i++) begin
            aa = AW'(20 + i);
            step(1'b1, 1'b1, aa, 8'(8'hA0 + i), 1'b1, 1'b1, aa, 8'(8'hB0 + i), xa, xb);
            if (!xa) step(1'b1, 1'b1, aa, 8'(8'hA0 + i), 1'b0, 1'b0, 6'd0, 8'h00, xa, xb);
            else     step(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, aa, 8'(8'hB0 + i), xa, xb);
        end
        chk("t6_cnt_sat", 32'(coll_cnt), 3);
        for (int i = 0; i < 5; i++) begin
            aa = AW'(20 + i);
            step(1'b1, 1'b0, aa, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, xa, xb);
            chk("t6_final", 32'(a_if.rsp_rdata), (i % 2 == 0) ? 32'(8'hB0 + i) : 32'(8'hA0 + i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
